// File: rtl/data_bus_bridge.sv
// data_bus_bridge
//   Bridge sitting directly behind the CPU data-memory port. It decodes the word
//   address and serves a local data RAM plus a small MMIO map:
//     MMIO_BASE+0 TX_DATA  W: push into TX FIFO, R: 0
//     MMIO_BASE+1 STATUS   R: [7:0] count, [8] full, [9] empty, [10] overflow
//                          W: bit 10 set clears overflow
//     MMIO_BASE+2 LED      R/W low 8 bits
//     MMIO_BASE+3 CYCLE    R: free-running counter, W (any value): clear
//   Reads are combinational because the CPU never stalls. Writes commit on CLK.
//   The TX FIFO is first-word fall-through and drains over valid/ready.
//
//   Optional feature macro: DATA_BUS_BRIDGE_CYCLE_CNT_EN
//     defined   -> CYCLE counter present
//     undefined -> no counter flops; CYCLE reads 0 and writes to it are ignored
//
// Ports
//   CLK           clock, rising edge
//   RST           asynchronous reset, active low
//   address_i     word address
//   data_i        write data
//   we_i          write enable
//   data_o        combinational read data
//   tx_data_o     FIFO head word (0 when empty)
//   tx_valid_o    FIFO non-empty
//   tx_ready_i    consumer takes the head when high together with tx_valid_o
//   led_o         LED register
//   decode_err_o  sticky flag: a write to an unmapped address was seen
module data_bus_bridge #(
  parameter int            N          = 32,
  parameter int            RAM_WORDS  = 256,
  parameter int            FIFO_DEPTH = 8,
  parameter logic [N-1:0]  MMIO_BASE  = 32'h0000_8000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] address_i,
  input  logic [N-1:0] data_i,
  input  logic         we_i,
  output logic [N-1:0] data_o,
  output logic [N-1:0] tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic [7:0]   led_o,
  output logic         decode_err_o
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [N:0]   RAM_LIM = (N+1)'(RAM_WORDS);
  localparam logic [N-1:0] A_TX    = MMIO_BASE;
  localparam logic [N-1:0] A_STAT  = MMIO_BASE + N'(1);
  localparam logic [N-1:0] A_LED   = MMIO_BASE + N'(2);
  localparam logic [N-1:0] A_CYC   = MMIO_BASE + N'(3);

  logic is_ram, is_tx, is_stat, is_led, is_cyc, mapped;

  logic [N-1:0]  ram      [RAM_WORDS];
  logic [N-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, full, empty;
  logic          push_req, push_ok, pop;
  logic [N-1:0]  status_rd;
  logic [N-1:0]  cycle_rd;

  assign is_ram  = ({1'b0, address_i} < RAM_LIM);
  assign is_tx   = (address_i == A_TX);
  assign is_stat = (address_i == A_STAT);
  assign is_led  = (address_i == A_LED);
  // CYCLE stays mapped even without the counter so writes there are not errors.
  assign is_cyc  = (address_i == A_CYC);
  assign mapped  = is_ram | is_tx | is_stat | is_led | is_cyc;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = we_i & is_tx;
  assign pop      = ~empty & tx_ready_i;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok  = push_req & (~full | pop);

  assign tx_valid_o = ~empty;
  assign tx_data_o  = empty ? '0 : fifo_mem[rd_ptr];

  // RAM and FIFO storage are not reset; the FIFO output is gated by empty.
  always_ff @(posedge CLK) begin
    if (we_i && is_ram) ram[address_i[AW-1:0]] <= data_i;
  end

  always_ff @(posedge CLK) begin
    if (push_ok) fifo_mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      led_o        <= '0;
      decode_err_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (push_req && full && !pop)
        overflow <= 1'b1;
      else if (we_i && is_stat && data_i[10])
        overflow <= 1'b0;
      if (we_i && is_led)  led_o        <= data_i[7:0];
      if (we_i && !mapped) decode_err_o <= 1'b1;
    end
  end

`ifdef DATA_BUS_BRIDGE_CYCLE_CNT_EN
  logic [N-1:0] cycle_cnt;

  // A write clears the counter and takes priority over the increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      cycle_cnt <= '0;
    else if (we_i && is_cyc)
      cycle_cnt <= '0;
    else
      cycle_cnt <= cycle_cnt + N'(1);
  end

  assign cycle_rd = cycle_cnt;
`else
  assign cycle_rd = '0;
`endif

  always_comb begin
    status_rd      = '0;
    status_rd[7:0] = 8'(count);
    status_rd[8]   = full;
    status_rd[9]   = empty;
    status_rd[10]  = overflow;
  end

  // RAM read is asynchronous: a same-cycle write to the same word returns old data.
  always_comb begin
    data_o = '0;
    if (is_ram)
      data_o = ram[address_i[AW-1:0]];
    else if (is_stat)
      data_o = status_rd;
    else if (is_led)
      data_o[7:0] = led_o;
    else if (is_cyc)
      data_o = cycle_rd;
  end

endmodule
